// File: rtl/muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_unit_pkg
// Shared constants for the iterative RV32M multiply/divide unit:
//   - MDOP_* opcodes (equal to the instruction funct3 field)
//   - FSM state encoding
//   - iteration count and the operand width
//   - md_mag(): two's-complement magnitude helper used when latching operands
// -----------------------------------------------------------------------------
package muldiv_unit_pkg;

    localparam int XLEN     = 32;
    localparam int MD_ITERS = 32;

    localparam logic [2:0] MDOP_MUL    = 3'b000;
    localparam logic [2:0] MDOP_MULH   = 3'b001;
    localparam logic [2:0] MDOP_MULHSU = 3'b010;
    localparam logic [2:0] MDOP_MULHU  = 3'b011;
    localparam logic [2:0] MDOP_DIV    = 3'b100;
    localparam logic [2:0] MDOP_DIVU   = 3'b101;
    localparam logic [2:0] MDOP_REM    = 3'b110;
    localparam logic [2:0] MDOP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

    // Magnitude of v when it is interpreted as signed; v unchanged otherwise.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [XLEN-1:0] md_mag(input logic [XLEN-1:0] v,
                                                input logic            is_signed);
        return (is_signed && v[XLEN-1]) ? ({XLEN{1'b0}} - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_unit_if
// Request/response bundle between the execute stage (master) and the
// multiply/divide unit (slave).
//
// Handshake: the master raises start with op/a/b for one cycle; the request
// is taken on that rising edge only if the unit is idle (busy low) and flush
// is low, otherwise it is dropped, never queued. The unit then holds busy
// until the result cycle, pulses valid for exactly one cycle with result,
// and keeps result stable until the next accepted request. flush kills any
// in-flight request without producing valid.
//
// Signals:
//   start  (m->s) request strobe
//   op     (m->s) MDOP_* opcode
//   a, b   (m->s) rs1 / rs2 operands
//   flush  (m->s) pipeline kill
//   busy   (s->m) operation in flight
//   valid  (s->m) one-cycle result strobe
//   result (s->m) registered result
// -----------------------------------------------------------------------------
interface muldiv_unit_if;
    import muldiv_unit_pkg::*;

    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            valid;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, a, b, flush,
        input  busy, valid, result
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, valid, result
    );

endinterface

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit. A 32-step shift-add multiply or a
// 32-step restoring divide runs on unsigned magnitudes; a final FIX cycle
// applies the result sign and selects the requested half / quotient /
// remainder. Divide-by-zero and signed overflow finish on the accepting edge.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   bus          muldiv_unit_if.slave (start/op/a/b/flush in, busy/valid/result out)
//   o_dbg_state  current FSM state
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    muldiv_unit_if.slave        bus,
    output md_state_t           o_dbg_state
);

    md_state_t         r_state;
    logic [2:0]        r_op;
    // Multiply: {partial product high, multiplier}; divide: {remainder, dividend/quotient}.
    logic [2*XLEN-1:0] r_acc;
    // Multiplicand or divisor magnitude.
    logic [XLEN-1:0]   r_opnd;
    // Product sign for multiply, quotient sign for divide.
    logic              r_neg_lo;
    logic              r_neg_rem;
    logic [5:0]        r_cnt;
    logic              r_busy;
    logic              r_valid;
    logic [XLEN-1:0]   r_result;

    // ---------------------------------------------------------------- accept
    logic            w_a_signed;
    logic            w_b_signed;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic [XLEN-1:0] w_special_res;

    always_comb begin
        w_a_signed = (bus.op == MDOP_MULH) || (bus.op == MDOP_MULHSU) ||
                     (bus.op == MDOP_DIV)  || (bus.op == MDOP_REM);
        w_b_signed = (bus.op == MDOP_MULH) ||
                     (bus.op == MDOP_DIV)  || (bus.op == MDOP_REM);
        w_a_mag    = md_mag(bus.a, w_a_signed);
        w_b_mag    = md_mag(bus.b, w_b_signed);
        w_div_zero = bus.op[2] && (bus.b == '0);
        w_div_ovf  = ((bus.op == MDOP_DIV) || (bus.op == MDOP_REM)) &&
                     (bus.a == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (bus.b == {XLEN{1'b1}});

        w_special_res = '0;
        if (w_div_zero) begin
            // op[1] distinguishes REM/REMU from DIV/DIVU.
            w_special_res = bus.op[1] ? bus.a : {XLEN{1'b1}};
        end else if (w_div_ovf) begin
            w_special_res = bus.op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // ------------------------------------------------------- shared datapath
    // One 33-bit adder: add for multiply, subtract for divide.
    logic [XLEN:0]     w_add_x;
    logic [XLEN:0]     w_add_y;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_acc_next;

    always_comb begin
        w_add_x = r_op[2] ? r_acc[2*XLEN-1:XLEN-1] : {1'b0, r_acc[2*XLEN-1:XLEN]};
        w_add_y = {1'b0, r_opnd};
        w_sum   = r_op[2] ? (w_add_x - w_add_y) : (w_add_x + w_add_y);

        if (r_op[2]) begin
            // Restoring step: keep the difference when it did not go negative.
            if (w_sum[XLEN]) begin
                w_acc_next = {r_acc[2*XLEN-2:0], 1'b0};
            end else begin
                w_acc_next = {w_sum[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
            end
        end else begin
            // Shift-add step: the adder carry becomes the new product MSB.
            if (r_acc[0]) begin
                w_acc_next = {w_sum, r_acc[XLEN-1:1]};
            end else begin
                w_acc_next = {1'b0, r_acc[2*XLEN-1:1]};
            end
        end
    end

    // ---------------------------------------------------------------- fix-up
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_res;

    always_comb begin
        w_prod = r_neg_lo  ? ({(2*XLEN){1'b0}} - r_acc) : r_acc;
        w_quot = r_neg_lo  ? ({XLEN{1'b0}} - r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
        w_rem  = r_neg_rem ? ({XLEN{1'b0}} - r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];

        w_fix_res = '0;
        case (r_op)
            MDOP_MUL:                          w_fix_res = w_prod[XLEN-1:0];
            MDOP_MULH, MDOP_MULHSU, MDOP_MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
            MDOP_DIV, MDOP_DIVU:               w_fix_res = w_quot;
            MDOP_REM, MDOP_REMU:               w_fix_res = w_rem;
            default:                           w_fix_res = '0;
        endcase
    end

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= MD_IDLE;
            r_op      <= MDOP_MUL;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_neg_lo  <= 1'b0;
            r_neg_rem <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_result  <= '0;
        end else if (bus.flush) begin
            // Kill: back to idle, no strobe, result untouched.
            r_state <= MD_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    r_valid <= 1'b0;
                    if (bus.start) begin
                        r_op      <= bus.op;
                        r_acc     <= {{XLEN{1'b0}}, w_a_mag};
                        r_opnd    <= w_b_mag;
                        r_neg_lo  <= (w_a_signed & bus.a[XLEN-1]) ^ (w_b_signed & bus.b[XLEN-1]);
                        r_neg_rem <= w_a_signed & bus.a[XLEN-1];
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        if (w_div_zero || w_div_ovf) begin
                            r_result <= w_special_res;
                            r_valid  <= 1'b1;
                            r_state  <= MD_DONE;
                        end else begin
                            r_state  <= MD_BUSY;
                        end
                    end
                end
                MD_BUSY: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'(MD_ITERS - 1)) begin
                        r_state <= MD_FIX;
                    end
                end
                MD_FIX: begin
                    r_result <= w_fix_res;
                    r_valid  <= 1'b1;
                    r_state  <= MD_DONE;
                end
                MD_DONE: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= MD_IDLE;
                end
                default: begin
                    r_state <= MD_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.valid   = r_valid;
    assign bus.result  = r_result;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit: directed vectors, special cases,
// control scenarios (flush, reset, ignored start) and random operations
// checked against an arithmetic reference model via an expected queue.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int MAX_WAIT = 60;
    localparam int LAT_NORM = 34;
    localparam int LAT_SPEC = 1;

    logic      clk;
    logic      rst;
    md_state_t dbg_state;

    muldiv_unit_if bus();

    muldiv_unit dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ------------------------------------------------------- clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------- scoreboard
    logic [31:0] exp_q[$];
    int          n_run;
    int          n_fail;
    logic [31:0] last_res;

    // Arithmetic reference for all eight ops, including RISC-V special cases.
    function automatic logic [31:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0]        p;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            MDOP_MUL:    begin p = {32'd0, a} * {32'd0, b};             return p[31:0];  end
            MDOP_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            MDOP_MULHSU: begin p = {{32{a[31]}}, a} * {32'd0, b};       return p[63:32]; end
            MDOP_MULHU:  begin p = {32'd0, a} * {32'd0, b};             return p[63:32]; end
            MDOP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
            MDOP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MDOP_REM:    return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
            default:     return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
        if (op[2] && (b == 0)) return LAT_SPEC;
        if ((op == MDOP_DIV || op == MDOP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return LAT_SPEC;
        return LAT_NORM;
    endfunction

    // ------------------------------------------------------------- drivers
    // Called 1 time unit after a rising edge (start cycle). Returns 1 time
    // unit after the accepting edge, i.e. in cycle 1.
    task automatic pulse_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic start_op(input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
        exp_q.push_back(exp);
        pulse_start(op, a, b);
    endtask

    // Monitors from cycle 1 until valid (bounded). Optionally pokes a start
    // at cycle poke_cyc. Returns in the cycle after valid.
    task automatic collect(input int poke_cyc, output logic [31:0] res, output int lat,
                           output int busy_cyc, output bit got,
                           output logic post_busy, output logic post_valid);
        got      = 1'b0;
        lat      = 0;
        busy_cyc = 0;
        res      = '0;
        for (int cyc = 1; cyc <= MAX_WAIT && !got; cyc++) begin
            bus.start = (cyc == poke_cyc);
            if (cyc == poke_cyc) begin
                bus.op = MDOP_MUL;
                bus.a  = 32'd2;
                bus.b  = 32'd3;
            end
            if (bus.busy === 1'b1) busy_cyc++;
            if (bus.valid === 1'b1) begin
                got = 1'b1;
                lat = cyc;
                res = bus.result;
            end
            @(posedge clk); #1;
        end
        bus.start  = 1'b0;
        post_busy  = bus.busy;
        post_valid = bus.valid;
    endtask

    // --------------------------------------------------------------- tests
    task automatic test_reset();
        rst       = 1'b1;
        bus.flush = 1'b0;
        bus.start = 1'b1;
        bus.op    = MDOP_DIV;
        bus.a     = 32'd5;
        bus.b     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b0;
        rst       = 1'b0;
        @(posedge clk); #1;
        n_run++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_run++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
        n_run++; if (bus.result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", bus.result); end
        n_run++; if (dbg_state !== MD_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, MD_IDLE); end
        last_res = 32'd0;
    endtask

    task automatic test_mul();
        logic [31:0] res, exp;
        int          lat, bc;
        bit          got;
        logic        pb, pv;
        start_op(MDOP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        collect(0, res, lat, bc, got, pb, pv);
        exp = exp_q.pop_front();
        last_res = exp;
        n_run++; if (!got) begin n_fail++; $display("FAIL mul_timeout: got no valid expected valid"); end
        n_run++; if (res !== exp) begin n_fail++; $display("FAIL mul_result: got %h expected %h", res, exp); end
        n_run++; if (lat != LAT_NORM) begin n_fail++; $display("FAIL mul_latency: got %0d expected %0d", lat, LAT_NORM); end
        n_run++; if (bc != LAT_NORM) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d expected %0d", bc, LAT_NORM); end
        n_run++; if (pv !== 1'b0 || pb !== 1'b0) begin n_fail++; $display("FAIL mul_after_valid: got busy=%b valid=%b expected 0 0", pb, pv); end
        n_run++; if (bus.result !== exp) begin n_fail++; $display("FAIL mul_result_hold: got %h expected %h", bus.result, exp); end
    endtask

    task automatic test_mul_high();
        logic [2:0]  ops [3] = '{MDOP_MULH, MDOP_MULHU, MDOP_MULHSU};
        logic [31:0] av  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bv  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ev  [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] res, exp;
        int          lat, bc;
        bit          got;
        logic        pb, pv;
        for (int i = 0; i < 3; i++) begin
            start_op(ops[i], av[i], bv[i], ev[i]);
            collect(0, res, lat, bc, got, pb, pv);
            exp = exp_q.pop_front();
            last_res = exp;
            n_run++; if (res !== exp) begin n_fail++; $display("FAIL mulhi_result[%0d]: got %h expected %h", i, res, exp); end
            n_run++; if (lat != LAT_NORM) begin n_fail++; $display("FAIL mulhi_latency[%0d]: got %0d expected %0d", i, lat, LAT_NORM); end
        end
    endtask

    task automatic test_divide();
        logic [2:0]  ops [4] = '{MDOP_DIV, MDOP_REM, MDOP_DIVU, MDOP_REMU};
        logic [31:0] av  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] bv  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] ev  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        logic [31:0] res, exp;
        int          lat, bc;
        bit          got;
        logic        pb, pv;
        for (int i = 0; i < 4; i++) begin
            start_op(ops[i], av[i], bv[i], ev[i]);
            collect(0, res, lat, bc, got, pb, pv);
            exp = exp_q.pop_front();
            last_res = exp;
            n_run++; if (res !== exp) begin n_fail++; $display("FAIL div_result[%0d]: got %h expected %h", i, res, exp); end
            n_run++; if (lat != LAT_NORM) begin n_fail++; $display("FAIL div_latency[%0d]: got %0d expected %0d", i, lat, LAT_NORM); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops [5] = '{MDOP_DIV, MDOP_REM, MDOP_DIV, MDOP_REM, MDOP_REMU};
        logic [31:0] av  [5] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678};
        logic [31:0] bv  [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] ev  [5] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'h1234_5678};
        logic [31:0] res, exp;
        int          lat, bc;
        bit          got;
        logic        pb, pv;
        for (int i = 0; i < 5; i++) begin
            start_op(ops[i], av[i], bv[i], ev[i]);
            collect(0, res, lat, bc, got, pb, pv);
            exp = exp_q.pop_front();
            last_res = exp;
            n_run++; if (res !== exp) begin n_fail++; $display("FAIL special_result[%0d]: got %h expected %h", i, res, exp); end
            n_run++; if (lat != LAT_SPEC) begin n_fail++; $display("FAIL special_latency[%0d]: got %0d expected %0d", i, lat, LAT_SPEC); end
            n_run++; if (bc != 1) begin n_fail++; $display("FAIL special_busy_cycles[%0d]: got %0d expected 1", i, bc); end
        end
    endtask

    task automatic test_flush();
        bit seen_valid;
        pulse_start(MDOP_MUL, 32'd11, 32'd13);
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        n_run++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", bus.busy); end
        n_run++; if (dbg_state !== MD_IDLE) begin n_fail++; $display("FAIL flush_state: got %0d expected %0d", dbg_state, MD_IDLE); end
        seen_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.valid !== 1'b0) seen_valid = 1'b1;
            @(posedge clk); #1;
        end
        n_run++; if (seen_valid) begin n_fail++; $display("FAIL flush_no_valid: got valid=1 expected no valid"); end
        n_run++; if (bus.result !== last_res) begin n_fail++; $display("FAIL flush_result_kept: got %h expected %h", bus.result, last_res); end
    endtask

    task automatic test_start_while_busy();
        logic [31:0] res, exp;
        int          lat, bc;
        bit          got;
        logic        pb, pv;
        start_op(MDOP_DIVU, 32'd100, 32'd7, 32'd14);
        collect(5, res, lat, bc, got, pb, pv);
        exp = exp_q.pop_front();
        last_res = exp;
        n_run++; if (res !== exp) begin n_fail++; $display("FAIL busy_start_result: got %h expected %h", res, exp); end
        n_run++; if (lat != LAT_NORM) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected %0d", lat, LAT_NORM); end
        n_run++; if (pb !== 1'b0) begin n_fail++; $display("FAIL busy_start_not_queued: got busy=%b expected 0", pb); end
    endtask

    task automatic test_flush_start();
        bit seen;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = MDOP_DIV;
        bus.a     = 32'd5;
        bus.b     = 32'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_run++; if (seen) begin n_fail++; $display("FAIL flush_start_dropped: got activity expected none"); end
        n_run++; if (bus.result !== last_res) begin n_fail++; $display("FAIL flush_start_result: got %h expected %h", bus.result, last_res); end
    endtask

    task automatic test_rst_mid();
        logic [31:0] res, exp;
        int          lat, bc;
        bit          got;
        logic        pb, pv;
        pulse_start(MDOP_MUL, 32'd1000, 32'd1000);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_run++; if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctrl: got busy=%b valid=%b expected 0 0", bus.busy, bus.valid); end
        n_run++; if (bus.result !== 32'd0) begin n_fail++; $display("FAIL rst_mid_result: got %h expected 0", bus.result); end
        start_op(MDOP_MULHU, 32'd3, 32'd5, 32'd0);
        collect(0, res, lat, bc, got, pb, pv);
        exp = exp_q.pop_front();
        last_res = exp;
        n_run++; if (!got || res !== exp) begin n_fail++; $display("FAIL rst_mid_next_result: got %h expected %h", res, exp); end
        n_run++; if (lat != LAT_NORM) begin n_fail++; $display("FAIL rst_mid_next_latency: got %0d expected %0d", lat, LAT_NORM); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops [3] = '{MDOP_REMU, MDOP_DIVU, MDOP_MUL};
        logic [31:0] av  [3] = '{32'd77, 32'd9, 32'h0001_0001};
        logic [31:0] bv  [3] = '{32'd10, 32'd0, 32'h0001_0001};
        logic [31:0] res, exp;
        int          lat, bc;
        bit          got;
        logic        pb, pv;
        for (int i = 0; i < 3; i++) begin
            start_op(ops[i], av[i], bv[i], model(ops[i], av[i], bv[i]));
            collect(0, res, lat, bc, got, pb, pv);
            exp = exp_q.pop_front();
            last_res = exp;
            n_run++; if (res !== exp) begin n_fail++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, res, exp); end
            n_run++; if (lat != model_lat(ops[i], av[i], bv[i])) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, lat, model_lat(ops[i], av[i], bv[i])); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, res, exp;
        int          lat, bc, sel, elat;
        bit          got;
        logic        pb, pv;
        for (int i = 0; i < 24; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) b = 32'($urandom_range(1, 15));
            elat = model_lat(op, a, b);
            start_op(op, a, b, model(op, a, b));
            collect(0, res, lat, bc, got, pb, pv);
            exp = exp_q.pop_front();
            last_res = exp;
            n_run++; if (res !== exp) begin n_fail++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, res, exp); end
            n_run++; if (lat != elat) begin n_fail++; $display("FAIL rand_latency[%0d] op=%0d: got %0d expected %0d", i, op, lat, elat); end
        end
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        n_run     = 0;
        n_fail    = 0;
        last_res  = '0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = MDOP_MUL;
        bus.a     = '0;
        bus.b     = '0;

        test_reset();
        test_mul();
        test_mul_high();
        test_divide();
        test_special();
        test_flush();
        test_start_while_busy();
        test_flush_start();
        test_rst_mid();
        test_back_to_back();
        test_random();

        n_run++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size()); end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
